// File: rtl/joy_serial_reader.sv
// rtl/joy_serial_reader.sv - UserIO serial joystick reader: load/shift FSM, deserialiser, optional agreement filter
module joy_serial_reader #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 12,
    parameter int CLK_DIV = 12,
    parameter int GAP     = 64,
    parameter bit INVERT  = 1'b1,
    parameter bit FILTER  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load_n,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_valid,
    output logic                    busy
);

    localparam int N  = PLAYERS * BITS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [KW-1:0]   k_q, k_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [N-1:0]    prev_q, prev_d;
    logic [N-1:0]    joy_q, joy_d;
    logic            fv_q, fv_d;
    logic            busy_q, busy_d;
    logic            jclk_q, jclk_d;
    logic            load_n_q, load_n_d;
    logic            tick;
    logic [DW-1:0]   div_run;
    logic [N-1:0]    agree;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_run = tick ? '0 : div_q + DW'(1);
        agree   = ~(shift_q ^ prev_q);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        k_d     = k_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        prev_d  = prev_q;
        joy_d   = joy_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                div_d = div_run;
                if (tick) begin
                    k_d     = '0;
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                div_d = div_run;
                if (tick) begin
                    shift_d[k_q] = joy_data ^ INVERT;
                    state_d      = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                div_d = div_run;
                if (tick) begin
                    if (k_q == K_LAST) begin
                        // Commit on entry to LATCH so joystick and frame_valid appear together
                        state_d = S_LATCH;
                        prev_d  = shift_q;
                        if (FILTER) begin
                            joy_d = (agree & shift_q) | (~agree & joy_q);
                        end else begin
                            joy_d = shift_q;
                        end
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_SHIFT_LO;
                    end
                end
            end
            S_LATCH: begin
                div_d   = '0;
                gap_d   = '0;
                state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                div_d = div_run;
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase

        // Line and status outputs are registered from the next state so they align with it
        jclk_d   = (state_d == S_SHIFT_HI);
        load_n_d = (state_d != S_LOAD);
        fv_d     = (state_d == S_LATCH);
        busy_d   = (state_d == S_LOAD) || (state_d == S_SHIFT_LO) ||
                   (state_d == S_SHIFT_HI) || (state_d == S_LATCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            k_q      <= '0;
            gap_q    <= '0;
            shift_q  <= '0;
            prev_q   <= '0;
            joy_q    <= '0;
            fv_q     <= 1'b0;
            busy_q   <= 1'b0;
            jclk_q   <= 1'b0;
            load_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            prev_q   <= prev_d;
            joy_q    <= joy_d;
            fv_q     <= fv_d;
            busy_q   <= busy_d;
            jclk_q   <= jclk_d;
            load_n_q <= load_n_d;
        end
    end

    assign joy_clk     = jclk_q;
    assign joy_load_n  = load_n_q;
    assign joystick    = joy_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// tb/tb_joy_serial_reader.sv - self-checking bench for joy_serial_reader with an adaptor and frame model
module tb_joy_serial_reader;

    localparam int N_A       = 8;
    localparam int CD_A      = 2;
    localparam int GAP_A     = 1;
    localparam int FRAME_A   = (1 + 2 * N_A + GAP_A) * CD_A + 1;
    localparam int BUSY_A    = FRAME_A - GAP_A * CD_A;
    localparam int PERIOD_A  = FRAME_A + 1;
    localparam int FRAME_D   = (1 + 2 * 1 + 0) * 1 + 1;
    localparam int PERIOD_D  = FRAME_D + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic enable_d = 1'b0;
    logic joy_data = 1'b1;
    logic joy_data_d = 1'b1;
    logic [7:0] line = 8'hFF;

    logic       jclk_a, load_n_a, fv_a, busy_a;
    logic       jclk_b, load_n_b, fv_b, busy_b;
    logic       jclk_c, load_n_c, fv_c, busy_c;
    logic       jclk_d, load_n_d, fv_d, busy_d;
    logic [7:0] joystick_a, joystick_b, joystick_c;
    logic [0:0] joystick_d;

    int n_chk = 0;
    int n_pass = 0;

    int cyc = 0;
    int m_load_lo = 0, m_clk_hi = 0, m_clk_rise = 0, m_fv_a = 0;
    int m_rise_last = 0, m_rise_prev = 0, m_fall = 0;
    int m_drise_last = 0, m_drise_prev = 0, m_dfall = 0;
    logic m_clk_prev = 1'b0, m_busy_prev = 1'b0, m_dbusy_prev = 1'b0;
    int ad_idx = 0;
    logic ad_clk_prev = 1'b0;

    logic [7:0] c_prev, c_out;

    always #5 clk = ~clk;

    joy_serial_reader #(.PLAYERS(2), .BITS(4), .CLK_DIV(2), .GAP(1), .INVERT(1'b1), .FILTER(1'b0)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .joy_data(joy_data),
        .joy_clk(jclk_a), .joy_load_n(load_n_a), .joystick(joystick_a),
        .frame_valid(fv_a), .busy(busy_a));

    joy_serial_reader #(.PLAYERS(2), .BITS(4), .CLK_DIV(2), .GAP(1), .INVERT(1'b0), .FILTER(1'b0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .joy_data(joy_data),
        .joy_clk(jclk_b), .joy_load_n(load_n_b), .joystick(joystick_b),
        .frame_valid(fv_b), .busy(busy_b));

    joy_serial_reader #(.PLAYERS(2), .BITS(4), .CLK_DIV(2), .GAP(1), .INVERT(1'b1), .FILTER(1'b1)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .joy_data(joy_data),
        .joy_clk(jclk_c), .joy_load_n(load_n_c), .joystick(joystick_c),
        .frame_valid(fv_c), .busy(busy_c));

    joy_serial_reader #(.PLAYERS(1), .BITS(1), .CLK_DIV(1), .GAP(0), .INVERT(1'b1), .FILTER(1'b0)) u_d (
        .clk(clk), .reset(reset), .enable(enable_d), .joy_data(joy_data_d),
        .joy_clk(jclk_d), .joy_load_n(load_n_d), .joystick(joystick_d),
        .frame_valid(fv_d), .busy(busy_d));

    // Adaptor: parallel load resets the bit pointer, each rising shift clock advances it
    always @(negedge clk) begin
        if (!load_n_a) ad_idx = 0;
        else if (jclk_a && !ad_clk_prev) ad_idx = ad_idx + 1;
        ad_clk_prev = jclk_a;
        joy_data = (ad_idx < 8) ? line[ad_idx[2:0]] : 1'b1;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!load_n_a) m_load_lo = m_load_lo + 1;
        if (jclk_a) m_clk_hi = m_clk_hi + 1;
        if (jclk_a && !m_clk_prev) m_clk_rise = m_clk_rise + 1;
        m_clk_prev = jclk_a;
        if (fv_a) m_fv_a = m_fv_a + 1;
        if (busy_a && !m_busy_prev) begin
            m_rise_prev = m_rise_last;
            m_rise_last = cyc;
        end
        if (!busy_a && m_busy_prev) m_fall = cyc;
        m_busy_prev = busy_a;
        if (busy_d && !m_dbusy_prev) begin
            m_drise_prev = m_drise_last;
            m_drise_last = cyc;
        end
        if (!busy_d && m_dbusy_prev) m_dfall = cyc;
        m_dbusy_prev = busy_d;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_fv_a(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!fv_a && k < 400);
        chk({tag, "_fv_seen"}, 32'(fv_a), 32'd1);
    endtask

    task automatic wait_fv_d(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!fv_d && k < 50);
        chk({tag, "_fv_seen"}, 32'(fv_d), 32'd1);
    endtask

    // Frame model: sampled bit = line level XOR INVERT; filter passes a bit only when two frames agree
    task automatic check_frame(input string tag);
        logic [7:0] s_inv, exp_a, exp_b;
        s_inv = ~line;
        exp_a = s_inv;
        exp_b = line;
        for (int i = 0; i < 8; i++) begin
            if (s_inv[i] == c_prev[i]) c_out[i] = s_inv[i];
        end
        c_prev = s_inv;
        chk({tag, "_joy_a"}, 32'(joystick_a), 32'(exp_a));
        chk({tag, "_joy_b"}, 32'(joystick_b), 32'(exp_b));
        chk({tag, "_joy_c"}, 32'(joystick_c), 32'(c_out));
        chk({tag, "_fv_bc"}, 32'({fv_b, fv_c}), 32'd3);
    endtask

    initial begin
        int s_load, s_hi, s_rise, s_fv, k;
        c_prev = '0;
        c_out  = '0;

        repeat (3) step();
        chk("rst_joy_clk", 32'(jclk_a), 32'd0);
        chk("rst_load_n", 32'(load_n_a), 32'd1);
        chk("rst_joystick", 32'(joystick_a), 32'd0);
        chk("rst_fv", 32'(fv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_joy_d", 32'(joystick_d), 32'd0);

        reset = 1'b0;
        repeat (5) step();
        chk("idle_load_n", 32'(load_n_a), 32'd1);
        chk("idle_busy", 32'(busy_a), 32'd0);

        line   = 8'hA5;
        s_load = m_load_lo;
        s_hi   = m_clk_hi;
        s_rise = m_clk_rise;
        enable = 1'b1;
        wait_fv_a("a5");
        check_frame("a5");
        chk("a5_joy_a_const", 32'(joystick_a), 32'h5A);
        chk("a5_joy_b_const", 32'(joystick_b), 32'hA5);
        chk("a5_p1_b0", 32'(joystick_b[4]), 32'd0);
        chk("a5_load_lo_cycles", 32'(m_load_lo - s_load), 32'd2);
        chk("a5_clk_hi_cycles", 32'(m_clk_hi - s_hi), 32'(2 * N_A));
        chk("a5_clk_pulses", 32'(m_clk_rise - s_rise), 32'(N_A));
        line = 8'hFE;
        step();
        chk("a5_fv_one_cycle", 32'(fv_a), 32'd0);
        chk("a5_busy_len", 32'(m_fall - m_rise_last), 32'(BUSY_A));

        // Logical 0x01,0x00,0x01,0x01 through the filter, then random patterns
        for (int i = 0; i < 10; i++) begin
            if (i == 1) line = 8'hFF;
            else if (i < 4) line = 8'hFE;
            else line = 8'($urandom);
            if (i > 0) step();
            wait_fv_a($sformatf("f%0d", i));
            check_frame($sformatf("f%0d", i));
            if (i == 0) chk("period_a", 32'(m_rise_last - m_rise_prev), 32'(PERIOD_A));
            if (i == 3) chk("filter_agree_01", 32'(joystick_c), 32'h01);
        end

        line = 8'($urandom);
        k = 0;
        do begin
            step();
            k++;
        end while (!busy_a && k < 100);
        chk("drop_frame_started", 32'(busy_a), 32'd1);
        repeat (10) step();
        enable = 1'b0;
        s_fv   = m_fv_a;
        wait_fv_a("drop");
        check_frame("drop");
        repeat (20) step();
        chk("drop_fv_once", 32'(m_fv_a - s_fv), 32'd1);
        chk("drop_idle_busy", 32'(busy_a), 32'd0);
        chk("drop_idle_load_n", 32'(load_n_a), 32'd1);
        chk("drop_idle_joy_clk", 32'(jclk_a), 32'd0);

        enable = 1'b1;
        step();
        chk("reraise_load_n", 32'(load_n_a), 32'd0);
        chk("reraise_busy", 32'(busy_a), 32'd1);

        s_rise = m_clk_rise;
        k = 0;
        do begin
            step();
            k++;
        end while (!(jclk_a && (m_clk_rise - s_rise == 6)) && k < 200);
        chk("bit5_hi_reached", 32'(jclk_a), 32'd1);
        reset = 1'b1;
        step();
        c_prev = '0;
        c_out  = '0;
        chk("mid_rst_joy_clk", 32'(jclk_a), 32'd0);
        chk("mid_rst_load_n", 32'(load_n_a), 32'd1);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_joy_a", 32'(joystick_a), 32'd0);
        chk("mid_rst_joy_c", 32'(joystick_c), 32'd0);
        reset = 1'b0;
        s_fv  = m_fv_a;
        repeat (30) step();
        chk("mid_rst_no_early_fv", 32'(m_fv_a - s_fv), 32'd0);
        wait_fv_a("post_rst");
        check_frame("post_rst");
        enable = 1'b0;
        repeat (10) step();

        joy_data_d = 1'b0;
        enable_d   = 1'b1;
        wait_fv_d("d0");
        chk("d0_joy", 32'(joystick_d), 32'd1);
        joy_data_d = 1'b1;
        step();
        chk("d0_fv_one_cycle", 32'(fv_d), 32'd0);
        chk("d0_busy_len", 32'(m_dfall - m_drise_last), 32'(FRAME_D));
        wait_fv_d("d1");
        chk("d1_joy", 32'(joystick_d), 32'd0);
        chk("d_period", 32'(m_drise_last - m_drise_prev), 32'(PERIOD_D));
        enable_d = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
